// File: rtl/fact_unit.sv
// -----------------------------------------------------------------------------
// fact_unit -- memory-mapped iterative factorial accelerator
//
// Register-side responder behind the SoC factorial address decoder. Software
// writes n, then writes go=1. The unit computes n! with one multiply per
// cycle and presents n / go / status / result on the read bus.
//
// Ports
//   clk    in   1    system clock, rising-edge active
//   rst_n  in   1    synchronous active-low reset
//   we1    in   1    write strobe for the n register
//   we2    in   1    write strobe for the go register
//   rdsel  in   2    read select: 00 n, 01 go, 10 status {err,done}, 11 result
//   wd     in   D_W  bus write data
//   rd     out  D_W  bus read data (combinational mux of registers)
//   done   out  1    computation finished (status bit 0)
//   err    out  1    last request had n > MAX_N (status bit 1)
// -----------------------------------------------------------------------------
module fact_unit #(
    parameter int N_W   = 4,
    parameter int D_W   = 32,
    parameter int MAX_N = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we1,
    input  logic           we2,
    input  logic [1:0]     rdsel,
    input  logic [D_W-1:0] wd,
    output logic [D_W-1:0] rd,
    output logic           done,
    output logic           err
);

    localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);
    localparam logic [N_W-1:0] ONE_N   = N_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q;
    logic [N_W-1:0] n_q;
    logic [N_W-1:0] cnt_q;
    logic           go_q;
    logic [D_W-1:0] prod_q;
    logic [D_W-1:0] result_q;
    logic           done_q;
    logic           err_q;

    logic           start;
    logic [D_W-1:0] prod_d;
    logic [N_W-1:0] cnt_d;

    // Only the low bits of the write data carry register contents.
    logic unused_wd;
    assign unused_wd = ^wd[D_W-1:N_W];

    // A go write only launches a job from IDLE; while BUSY it just updates go.
    assign start = we2 & wd[0] & (state_q == IDLE);

    // One multiply step: cnt is zero-extended; MAX_N bounds the product so
    // truncation to D_W never loses bits.
    assign prod_d = prod_q * D_W'(cnt_q);
    assign cnt_d  = cnt_q - ONE_N;

    // NOTE: all state lives in one clocked block using non-blocking assignments,
    // so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            go_q     <= 1'b0;
            prod_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (we1) begin
                n_q <= wd[N_W-1:0];
            end
            if (we2) begin
                go_q <= wd[0];
            end

            // FSM assignments follow the register writes so that its clear of
            // go takes effect over a same-cycle bus write.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (n_q > MAX_N_V) begin
                            err_q    <= 1'b1;
                            done_q   <= 1'b1;
                            result_q <= '0;
                            go_q     <= 1'b0;
                        end else begin
                            err_q   <= 1'b0;
                            done_q  <= 1'b0;
                            prod_q  <= D_W'(1);
                            cnt_q   <= n_q;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q > ONE_N) begin
                        prod_q <= prod_d;
                        cnt_q  <= cnt_d;
                    end else begin
                        // cnt of 0 or 1 ends the job, which also yields 0! = 1.
                        result_q <= prod_q;
                        done_q   <= 1'b1;
                        go_q     <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every path assigns rd from a default first, so no latch is inferred.
    always_comb begin
        rd = '0;
        case (rdsel)
            2'b00: rd = D_W'(n_q);
            2'b01: rd = D_W'(go_q);
            2'b10: rd = D_W'({err_q, done_q});
            2'b11: rd = result_q;
            default: rd = '0;
        endcase
    end

    assign done = done_q;
    assign err  = err_q;

endmodule
